// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode, width and FSM state definitions
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;
  localparam int ALU_SHAMT_W    = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } shift_mode_e;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// rtl/alu_serial_shifter.sv - one-bit-per-cycle shifter with shift-amount down-counter
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int SHAMT_W    = ALU_SHAMT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  shift_mode_e           load_mode,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [SHAMT_W-1:0]    load_shamt,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] shift_next
);

  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;
  shift_mode_e           mode_q, mode_d;

  // done flags the cycle whose shift is the last one; shift_next is that final value
  assign done = (cnt_q == SHAMT_W'(1));

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    case (mode_q)
      SH_LL:   shift_next = {sreg_q[DATA_WIDTH-2:0], 1'b0};
      SH_RL:   shift_next = {1'b0, sreg_q[DATA_WIDTH-1:1]};
      default: shift_next = {sreg_q[DATA_WIDTH-1], sreg_q[DATA_WIDTH-1:1]};
    endcase
    if (load) begin
      sreg_d = load_data;
      cnt_d  = load_shamt;
      mode_d = load_mode;
    end else if (cnt_q != '0) begin
      sreg_d = shift_next;
      cnt_d  = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      mode_q <= SH_LL;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/alu_exec_mc.sv
// rtl/alu_exec_mc.sv - multicycle ALU: single-cycle ops plus serial shifts behind valid/ready
module alu_exec_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int SHAMT_W    = ALU_SHAMT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  illegal
);

  alu_state_e            state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  illegal_q, illegal_d;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  legal;
  logic [SHAMT_W-1:0]    shamt;
  logic                  sh_load;
  shift_mode_e           sh_mode;
  logic                  sh_done;
  logic [DATA_WIDTH-1:0] sh_next;

  assign shamt = src_b[SHAMT_W-1:0];

  // a zero-amount shift resolves here as a pass-through of src_a
  always_comb begin
    alu_res = '0;
    legal   = 1'b1;
    case (alu_ctrl)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, src_a < src_b};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = src_a;
      default: begin
        alu_res = '0;
        legal   = 1'b0;
      end
    endcase
  end

  always_comb begin
    sh_mode = (alu_ctrl == ALU_SLL) ? SH_LL : (alu_ctrl == ALU_SRL) ? SH_RL : SH_RA;
    sh_load = (state_q == ST_IDLE) && in_valid && is_shift(alu_ctrl) && (shamt != '0);
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (sh_load) begin
          state_d = ST_SHIFT;
        end else if (in_valid) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = alu_res;
          zero_d      = (alu_res == '0);
          illegal_d   = ~legal;
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = sh_next;
          zero_d      = (sh_next == '0);
          illegal_d   = 1'b0;
        end
      end
      default: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  alu_serial_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .SHAMT_W   (SHAMT_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_mode (sh_mode),
    .load_data (src_a),
    .load_shamt(shamt),
    .done      (sh_done),
    .shift_next(sh_next)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/alu_exec_mc.md
ALU_EXEC_MC -- requirements
Module: alu_exec_mc

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter: SHAMT_W, default 5, shift-amount width (log2 DATA_WIDTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 alu_ctrl  input  4  operation code (encoding per REQ-013).
REQ-008 src_a  input  DATA_WIDTH  operand A.
REQ-009 src_b  input  DATA_WIDTH  operand B; shift amount = src_b[SHAMT_W-1:0].
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result / zero / illegal  output  DATA_WIDTH / 1 / 1  registered result, result==0 flag, unsupported-code flag.

Function
REQ-013 Codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA; 10-15 illegal.
REQ-014 FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE.
REQ-015 Accept occurs when in_valid && in_ready; operands and code captured into internal registers at accept; later input changes ignored.
REQ-016 Codes 0-6 and illegal: result computed at accept, IDLE->DONE, out_valid asserted the cycle after accept (latency 1).
REQ-017 ADD/SUB wrap modulo 2^DATA_WIDTH; SLT/SLTU result is 0 or 1 zero-extended.
REQ-018 Shifts: accept loads src_a into shift register and shamt into down-counter; shamt==0 -> DONE directly (latency 1); else -> SHIFT.
REQ-019 SHIFT: one bit position per cycle (SLL fill 0, SRL fill 0, SRA fill sign bit), counter decrements; on counter reaching 0 -> DONE; total latency shamt+1 cycles, max 32.
REQ-020 DONE: result, zero, illegal held stable while out_valid=1 && out_ready=0.
REQ-021 DONE with out_ready=1: transfer completes, -> IDLE; new request not accepted in that same cycle (in_ready=0 in DONE).
REQ-022 zero = (result == 0), valid whenever out_valid=1; used by branch compare via SUB.
REQ-023 Illegal code: result=0, zero=1, illegal=1, latency 1; no error halt.
REQ-024 illegal=0 for all legal codes; outputs other than out_valid are don't-care-free: hold last value when out_valid=0.
REQ-025 in_valid while busy (SHIFT/DONE) has no effect; requester must hold until in_ready.

Reset
REQ-026 rst asserted at any time, including mid-SHIFT or DONE awaiting out_ready: state -> IDLE immediately, in-flight operation discarded.
REQ-027 Reset values: out_valid=0, result=0, zero=1, illegal=0, in_ready=1 (IDLE), shift counter=0.
REQ-028 First accept possible on the first rising edge after rst deasserts.

Structure
REQ-029 Shared package alu_pkg holds the alu_ctrl enum (4-bit, codes per REQ-013), DATA_WIDTH/SHAMT_W defaults and FSM state typedef; the control-unit decoder and this block both import it.
REQ-030 One sub-module: alu_serial_shifter (shift register, down-counter, done pulse); single-cycle ops stay in the top level.

Verification
REQ-031 ADD 0xFFFFFFFF + 0x00000001, out_ready=1 -> out_valid 1 cycle after accept, result=0, zero=1, illegal=0.
REQ-032 SLT 0xFFFFFFFF vs 0x00000001 -> result=1; SLTU same operands -> result=0.
REQ-033 SRA 0x80000000 by 4 -> out_valid 5 cycles after accept, result=0xF8000000; SLL 0x1 by 0 -> latency 1, result=0x1; SRL 0x80000000 by 31 -> latency 32, result=0x1.
REQ-034 SUB 5-5 with out_ready=0 for 3 cycles -> result=0, zero=1 held stable, in_ready=0 throughout, return to IDLE after out_ready=1.
REQ-035 Code 12 with any operands -> latency 1, illegal=1, result=0, zero=1.
REQ-036 rst pulsed during SLL by 20 at cycle 7 -> out_valid=0, in_ready=1 immediately; next ADD 2+3 -> result=5 latency 1.
